// File: rtl/array_packer_hs_if.sv
// Handshake bundle for the element-to-array packer: scalar producer side,
// array consumer side, and status. The slave modport is the packer itself.
interface array_packer_hs_if #(
    parameter int DATA_W  = 32,
    parameter int N_ELEMS = 2,
    parameter int CNT_W   = 8
);
    logic [DATA_W-1:0]             b_in;
    logic                          b_in_sync;
    logic                          b_in_notify;
    logic                          rev_mode;
    logic [N_ELEMS*DATA_W-1:0]     b_out;
    logic                          b_out_sync;
    logic                          b_out_notify;
    logic [$clog2(N_ELEMS+1)-1:0]  fill_level;
    logic [CNT_W-1:0]              frame_cnt;
    logic                          state_dbg;

    modport master (
        output b_in, b_in_sync, rev_mode, b_out_sync,
        input  b_in_notify, b_out, b_out_notify, fill_level, frame_cnt, state_dbg
    );

    modport slave (
        input  b_in, b_in_sync, rev_mode, b_out_sync,
        output b_in_notify, b_out, b_out_notify, fill_level, frame_cnt, state_dbg
    );
endinterface

// File: rtl/array_packer_hs.sv
// Packs N_ELEMS scalar words into one array, forward or reverse fill order,
// and holds it on b_out until the consumer takes it.
module array_packer_hs #(
    parameter int DATA_W  = 32,
    parameter int N_ELEMS = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    array_packer_hs_if.slave     bus
);
    // Handshake: a transfer happens only in a cycle where sync and notify are
    // both high; notify is a pure decode of the state register, never of sync.
    localparam int FL_W  = $clog2(N_ELEMS + 1);
    localparam int ARR_W = N_ELEMS * DATA_W;
    localparam logic [FL_W-1:0] LAST = FL_W'(N_ELEMS - 1);

    typedef enum logic {S_FILL = 1'b0, S_SEND = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [FL_W-1:0]    fill_q, fill_d;
    logic [ARR_W-1:0]   arr_q, arr_d;
    logic               order_q, order_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               eff_rev;
    logic [FL_W-1:0]    slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FILL;
            fill_q  <= '0;
            arr_q   <= '0;
            order_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            arr_q   <= arr_d;
            order_q <= order_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        arr_d   = arr_q;
        order_d = order_q;
        cnt_d   = cnt_q;
        // The first element of a frame samples rev_mode; later ones use the latched flag.
        eff_rev = (fill_q == '0) ? bus.rev_mode : order_q;
        slot    = eff_rev ? (LAST - fill_q) : fill_q;
        case (state_q)
            S_FILL: begin
                if (bus.b_in_sync) begin
                    order_d = eff_rev;
                    for (int k = 0; k < N_ELEMS; k++) begin
                        if (slot == FL_W'(k)) begin
                            arr_d[k*DATA_W +: DATA_W] = bus.b_in;
                        end
                    end
                    fill_d = fill_q + FL_W'(1);
                    if (fill_q == LAST) begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                // Array is left intact; the next frame overwrites it slot by slot.
                if (bus.b_out_sync) begin
                    state_d = S_FILL;
                    fill_d  = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign bus.b_in_notify  = (state_q == S_FILL);
    assign bus.b_out_notify = (state_q == S_SEND);
    assign bus.b_out        = arr_q;
    assign bus.fill_level   = fill_q;
    assign bus.frame_cnt    = cnt_q;
    assign bus.state_dbg    = (state_q == S_SEND);
endmodule

// File: tb/tb_array_packer_hs.sv
// Bench for array_packer_hs: a two-element packer with a 2-bit frame counter
// and a four-element packer, each with its own reference model and queue.
module tb_array_packer_hs;
    localparam int DW = 32;
    localparam int NA = 2;
    localparam int NB = 4;

    logic clk;
    logic rst;

    array_packer_hs_if #(.DATA_W(DW), .N_ELEMS(NA), .CNT_W(2)) if_a ();
    array_packer_hs_if #(.DATA_W(DW), .N_ELEMS(NB), .CNT_W(8)) if_b ();

    array_packer_hs #(.DATA_W(DW), .N_ELEMS(NA), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave)
    );
    array_packer_hs #(.DATA_W(DW), .N_ELEMS(NB), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [NA*DW-1:0] exp_a_q[$];
    logic [NB*DW-1:0] exp_b_q[$];
    logic [NA*DW-1:0] ma_arr;
    logic [NB*DW-1:0] mb_arr;
    int   ma_fill, mb_fill;
    logic ma_rev, mb_rev;
    logic [1:0] exp_cnt_a;
    logic [7:0] exp_cnt_b;

    task automatic clear_models();
        exp_a_q.delete();
        exp_b_q.delete();
        ma_arr = '0; mb_arr = '0;
        ma_fill = 0; mb_fill = 0;
        ma_rev = 1'b0; mb_rev = 1'b0;
        exp_cnt_a = '0; exp_cnt_b = '0;
    endtask

    task automatic idle_inputs();
        if_a.b_in = '0; if_a.b_in_sync = 1'b0; if_a.rev_mode = 1'b0; if_a.b_out_sync = 1'b0;
        if_b.b_in = '0; if_b.b_in_sync = 1'b0; if_b.rev_mode = 1'b0; if_b.b_out_sync = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_models();
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send_a(input logic [DW-1:0] d, input logic rv);
        int slot;
        n_cmp++;
        if (if_a.b_in_notify !== 1'b1) begin
            n_err++;
            $display("FAIL send_a_ready: b_in_notify=%b required 1", if_a.b_in_notify);
        end
        if_a.b_in = d; if_a.rev_mode = rv; if_a.b_in_sync = 1'b1;
        if (ma_fill == 0) ma_rev = rv;
        slot = ma_rev ? (NA - 1 - ma_fill) : ma_fill;
        ma_arr[slot*DW +: DW] = d;
        ma_fill++;
        if (ma_fill == NA) begin
            exp_a_q.push_back(ma_arr);
            ma_fill = 0;
        end
        @(negedge clk);
        if_a.b_in_sync = 1'b0;
    endtask

    task automatic send_b(input logic [DW-1:0] d, input logic rv);
        int slot;
        n_cmp++;
        if (if_b.b_in_notify !== 1'b1) begin
            n_err++;
            $display("FAIL send_b_ready: b_in_notify=%b required 1", if_b.b_in_notify);
        end
        if_b.b_in = d; if_b.rev_mode = rv; if_b.b_in_sync = 1'b1;
        if (mb_fill == 0) mb_rev = rv;
        slot = mb_rev ? (NB - 1 - mb_fill) : mb_fill;
        mb_arr[slot*DW +: DW] = d;
        mb_fill++;
        if (mb_fill == NB) begin
            exp_b_q.push_back(mb_arr);
            mb_fill = 0;
        end
        @(negedge clk);
        if_b.b_in_sync = 1'b0;
    endtask

    task automatic recv_a(input string name);
        logic [NA*DW-1:0] exp;
        int w = 0;
        while (if_a.b_out_notify !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (if_a.b_out_notify !== 1'b1) begin
            n_err++;
            $display("FAIL %s_a_timeout: b_out_notify=%b required 1", name, if_a.b_out_notify);
            return;
        end
        n_cmp++;
        if (if_a.fill_level !== 2'(NA)) begin
            n_err++;
            $display("FAIL %s_a_fill_full: got %0d required %0d", name, if_a.fill_level, NA);
        end
        n_cmp++;
        if (exp_a_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_a_unexpected: got %h required no frame", name, if_a.b_out);
        end else begin
            exp = exp_a_q.pop_front();
            if (if_a.b_out !== exp) begin
                n_err++;
                $display("FAIL %s_a_data: got %h required %h", name, if_a.b_out, exp);
            end
        end
        if_a.b_out_sync = 1'b1;
        @(negedge clk);
        if_a.b_out_sync = 1'b0;
        exp_cnt_a = exp_cnt_a + 2'd1;
        n_cmp++;
        if (if_a.frame_cnt !== exp_cnt_a) begin
            n_err++;
            $display("FAIL %s_a_frame_cnt: got %0d required %0d", name, if_a.frame_cnt, exp_cnt_a);
        end
        n_cmp++;
        if ({if_a.b_in_notify, if_a.b_out_notify, if_a.fill_level} !== 4'b1000) begin
            n_err++;
            $display("FAIL %s_a_refill: in_n=%b out_n=%b fill=%0d required 1 0 0", name,
                     if_a.b_in_notify, if_a.b_out_notify, if_a.fill_level);
        end
    endtask

    task automatic recv_b(input string name);
        logic [NB*DW-1:0] exp;
        int w = 0;
        while (if_b.b_out_notify !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (if_b.b_out_notify !== 1'b1) begin
            n_err++;
            $display("FAIL %s_b_timeout: b_out_notify=%b required 1", name, if_b.b_out_notify);
            return;
        end
        n_cmp++;
        if (exp_b_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_b_unexpected: got %h required no frame", name, if_b.b_out);
        end else begin
            exp = exp_b_q.pop_front();
            if (if_b.b_out !== exp) begin
                n_err++;
                $display("FAIL %s_b_data: got %h required %h", name, if_b.b_out, exp);
            end
        end
        if_b.b_out_sync = 1'b1;
        @(negedge clk);
        if_b.b_out_sync = 1'b0;
        exp_cnt_b = exp_cnt_b + 8'd1;
        n_cmp++;
        if (if_b.frame_cnt !== exp_cnt_b) begin
            n_err++;
            $display("FAIL %s_b_frame_cnt: got %0d required %0d", name, if_b.frame_cnt, exp_cnt_b);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        clear_models();
        for (int c = 0; c < 3; c++) begin
            if_a.b_in_sync = c[0]; if_a.b_out_sync = ~c[0]; if_a.b_in = $urandom;
            if_b.b_in_sync = ~c[0]; if_b.b_out_sync = c[0]; if_b.b_in = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({if_a.b_in_notify, if_a.b_out_notify} !== 2'b10 || if_a.b_out !== '0 ||
                if_a.frame_cnt !== '0 || if_a.fill_level !== '0) begin
                n_err++;
                $display("FAIL reset_a: in_n=%b out_n=%b b_out=%h cnt=%0d fill=%0d required 1 0 0 0 0",
                         if_a.b_in_notify, if_a.b_out_notify, if_a.b_out, if_a.frame_cnt, if_a.fill_level);
            end
            n_cmp++;
            if ({if_b.b_in_notify, if_b.b_out_notify} !== 2'b10 || if_b.b_out !== '0 ||
                if_b.frame_cnt !== '0 || if_b.fill_level !== '0) begin
                n_err++;
                $display("FAIL reset_b: in_n=%b out_n=%b b_out=%h cnt=%0d fill=%0d required 1 0 0 0 0",
                         if_b.b_in_notify, if_b.b_out_notify, if_b.b_out, if_b.frame_cnt, if_b.fill_level);
            end
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_forward();
        send_a(32'h11, 1'b0);
        n_cmp++;
        if (if_a.fill_level !== 2'd1) begin
            n_err++;
            $display("FAIL fwd_fill_one: got %0d required 1", if_a.fill_level);
        end
        send_a(32'h22, 1'b0);
        n_cmp++;
        if (if_a.b_in_notify !== 1'b0 || if_a.b_out_notify !== 1'b1) begin
            n_err++;
            $display("FAIL fwd_latency: in_n=%b out_n=%b required 0 1", if_a.b_in_notify, if_a.b_out_notify);
        end
        recv_a("fwd");
    endtask

    task automatic test_reverse();
        send_a(32'hA, 1'b1);
        send_a(32'hB, 1'b0);
        recv_a("rev");
    endtask

    task automatic test_backpressure();
        logic [NA*DW-1:0] held;
        apply_reset();
        send_a($urandom, 1'b0);
        send_a($urandom, 1'b1);
        held = exp_a_q[0];
        for (int c = 0; c < 5; c++) begin
            if_a.b_in_sync = 1'b1;
            if_a.b_in = $urandom;
            if_a.rev_mode = c[0];
            @(negedge clk);
            n_cmp++;
            if (if_a.b_out !== held || if_a.fill_level !== 2'd2 ||
                if_a.b_in_notify !== 1'b0 || if_a.b_out_notify !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold: b_out=%h fill=%0d in_n=%b out_n=%b required %h 2 0 1",
                         if_a.b_out, if_a.fill_level, if_a.b_in_notify, if_a.b_out_notify, held);
            end
        end
        if_a.b_in_sync = 1'b0;
        recv_a("bp");
        n_cmp++;
        if (if_a.b_out !== held) begin
            n_err++;
            $display("FAIL bp_not_cleared: got %h required %h", if_a.b_out, held);
        end
    endtask

    task automatic test_counter_wrap();
        int seq[5] = '{1, 2, 3, 0, 1};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            send_a($urandom, 1'($urandom_range(0, 1)));
            send_a($urandom, 1'($urandom_range(0, 1)));
            recv_a("wrap");
            n_cmp++;
            if (if_a.frame_cnt !== 2'(seq[k])) begin
                n_err++;
                $display("FAIL wrap_seq%0d: got %0d required %0d", k, if_a.frame_cnt, seq[k]);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        apply_reset();
        send_b(32'hDEAD0001, 1'b0);
        send_b(32'hDEAD0002, 1'b0);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (if_b.fill_level !== '0 || if_b.b_out !== '0 || if_b.b_in_notify !== 1'b1 ||
            if_b.b_out_notify !== 1'b0 || if_b.frame_cnt !== '0) begin
            n_err++;
            $display("FAIL midrst_async: fill=%0d b_out=%h in_n=%b out_n=%b cnt=%0d required 0 0 1 0 0",
                     if_b.fill_level, if_b.b_out, if_b.b_in_notify, if_b.b_out_notify, if_b.frame_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_models();
        for (int k = 0; k < NB; k++) send_b(32'h100 + 32'(k), 1'b0);
        recv_b("midrst_fwd");
        send_b(32'h201, 1'b1);
        send_b(32'h202, 1'b0);
        send_b(32'h203, 1'b0);
        send_b(32'h204, 1'b1);
        recv_b("midrst_rev");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NB; k++) send_b($urandom, 1'($urandom_range(0, 1)));
            recv_b("b2b");
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        clear_models();
        test_reset();
        test_forward();
        test_reverse();
        test_backpressure();
        test_counter_wrap();
        test_mid_frame_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/array_packer_hs.md
Name: array_packer_hs

Overview:
- Parametrised element-to-array packer with blocking sync/notify handshakes.
- Accepts N_ELEMS scalar words one per transfer on b_in, assembles them into an array register, and presents the complete array on b_out.
- Adds two features to the fixed two-element packer: selectable fill order, and frame/fill status outputs.
- Sits between a scalar producer and an array consumer in generated property-checked designs.

Parameters:
- DATA_W, 32, width of one element in bits.
- N_ELEMS, 2, number of elements per array (≥2).
- CNT_W, 8, width of frame counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- b_in  input  DATA_W  incoming element.
- b_in_sync  input  1  producer offers b_in.
- b_in_notify  output  1  block ready to accept b_in.
- rev_mode  input  1  fill order for next frame; 0 = forward, 1 = reverse.
- b_out  output  N_ELEMS*DATA_W  packed array; slot k = b_out[k*DATA_W +: DATA_W].
- b_out_sync  input  1  consumer accepts b_out.
- b_out_notify  output  1  array valid on b_out.
- fill_level  output  $clog2(N_ELEMS+1)  elements stored in current frame.
- frame_cnt  output  CNT_W  frames delivered since reset.

Behaviour:
- Transfer rules:
  - In-transfer = b_in_sync & b_in_notify in the same cycle.
  - Out-transfer = b_out_sync & b_out_notify in the same cycle.
  - A sync without notify has no effect.
- Reset (rst low, asynchronous; all values hold until the first rising clk after rst releases):
  - Array register all zeros; b_out = 0.
  - fill_level = 0, frame_cnt = 0, FSM = FILL.
  - b_in_notify = 1, b_out_notify = 0.
  - Internal order flag = 0.
- FSM state FILL:
  - b_in_notify = 1, b_out_notify = 0.
  - On in-transfer with element index i = fill_level:
    - If i == 0, latch rev_mode into the order flag (held for the whole frame).
    - Write b_in to slot i (forward) or slot N_ELEMS-1-i (reverse).
    - fill_level increments.
  - On the in-transfer where i == N_ELEMS-1: next cycle FSM = SEND, b_in_notify = 0, b_out_notify = 1, fill_level = N_ELEMS.
  - rev_mode changes while i > 0 have no effect.
- FSM state SEND:
  - b_in_notify = 0, b_out_notify = 1, b_out holds the full array stably.
  - b_in_sync is ignored; the array is not modified.
  - On out-transfer: next cycle FSM = FILL, b_in_notify = 1, b_out_notify = 0, fill_level = 0, frame_cnt increments (wraps 2^CNT_W-1 → 0).
  - The array register is NOT cleared; b_out shows old contents until overwritten slot by slot.
- Latency and throughput:
  - Latency is one cycle from the final in-transfer to b_out_notify.
  - Minimum frame period is N_ELEMS+1 cycles.
  - No in-transfer and out-transfer ever occur in the same cycle.
- All notify outputs and b_out are registered; none are combinational from sync inputs.
- Reset mid-frame or mid-SEND aborts immediately to reset values; the partial frame is discarded and frame_cnt is not incremented.
- b_out updates only on clk edges.
- Elements are stored as raw bits: no sign extension, no arithmetic on data.

Test Plan:
- Reset check (DATA_W=32, N_ELEMS=2): hold rst low, toggle the sync inputs → b_in_notify=1, b_out_notify=0, b_out=0, frame_cnt=0, fill_level=0.
- Forward frame: rev_mode=0, send 0x11 then 0x22 with b_in_sync=1 → cycle after second transfer b_out_notify=1, slot0=0x11, slot1=0x22, b_in_notify=0.
- Reverse frame: rev_mode=1 on first element, toggle rev_mode to 0 before the second; send 0xA then 0xB → slot0=0xB, slot1=0xA.
- Backpressure: frame complete, b_out_sync=0 for 5 cycles while b_in_sync=1 with new data → b_out stable, fill_level=2, no data accepted; then b_out_sync=1 for one cycle → frame_cnt=1, b_in_notify=1.
- Counter wrap: CNT_W=2, deliver 5 frames → frame_cnt sequence 1,2,3,0,1.
- Mid-frame reset: N_ELEMS=4, accept 2 elements, pulse rst low → fill_level=0, b_out=0, b_in_notify=1; the next frame of 4 packs correctly from slot 0.
